// File: rtl/seg_display_driver.sv
// Drives a 4-digit multiplexed 7-segment display from a 13-bit binary value.
// A bit-serial double-dabble engine converts to BCD; the scan shows only completed results.
module seg_display_driver #(
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] value,
  input  logic        load,
  input  logic        halt,
  output logic        busy,
  output logic        done,
  output logic [7:0]  seg,
  output logic [3:0]  dig
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;

  state_t         state, state_nxt;
  logic [12:0]    shift_q;
  logic [15:0]    bcd_q;
  logic [15:0]    disp_q;
  logic [3:0]     iter_q;
  logic           pend_q;
  logic [12:0]    pend_val;
  logic [DIV_W-1:0] div_q;
  logic [1:0]     idx_q;

  logic           start;
  logic [12:0]    start_val;
  logic           write_en;
  logic [3:0]     nib;
  logic           upper_zero;
  logic [7:0]     seg_nxt;

  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // A load seen in WRITE wins over an older pending value and restarts immediately.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    start_val = value;
    write_en  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          start     = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (iter_q == 4'd12) state_nxt = WRITE;
      end
      WRITE: begin
        write_en = 1'b1;
        if (load || pend_q) begin
          start     = 1'b1;
          start_val = load ? value : pend_val;
          state_nxt = CONV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: conversion engine, pending slot and display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      shift_q  <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      pend_val <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= write_en;
      if (start) begin
        shift_q <= start_val;
        bcd_q   <= '0;
        iter_q  <= '0;
      end else if (state == CONV) begin
        {bcd_q, shift_q} <= {dabble_adj(bcd_q), shift_q} << 1;
        iter_q           <= iter_q + 4'd1;
      end
      if (write_en) disp_q <= bcd_q;
      if (start) begin
        pend_q <= 1'b0;
      end else if (load && state != IDLE) begin
        pend_q   <= 1'b1;
        pend_val <= value;
      end
    end
  end

  always_comb begin
    nib = disp_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd3:    upper_zero = (disp_q[15:12] == 4'd0);
      2'd2:    upper_zero = (disp_q[15:8]  == 8'd0);
      2'd1:    upper_zero = (disp_q[15:4]  == 12'd0);
      default: upper_zero = 1'b0;
    endcase
    if (halt)                                  seg_nxt = 8'hBF;
    else if (BLANK_LEADING != 0 && upper_zero) seg_nxt = 8'hFF;
    else                                       seg_nxt = seg_code(nib);
  end

  // Stage boundary: scan divider and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      seg   <= 8'hFF;
      dig   <= 4'hF;
    end else begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      seg <= seg_nxt;
      dig <= ~(4'b0001 << idx_q);
    end
  end

endmodule
